// File: rtl/ped_signal_pkg.sv
// Shared encodings and defaults for the pedestrian crossing controller.
// The light-legality helper is kept here so any consumer of the light FSM agrees on it.
package ped_signal_pkg;

  typedef enum logic [1:0] {
    DW_STEADY = 2'b00,
    WALK      = 2'b01,
    FLASH     = 2'b10
  } ped_state_e;

  localparam int WALK_TICKS_DEF  = 16;
  localparam int FLASH_TICKS_DEF = 10;
  localparam int CNT_W_DEF       = 5;

  // Odd parity rules out 0 and 2 lamps lit; the AND term rules out all three.
  function automatic logic lights_one_hot(input logic red, input logic yellow, input logic green);
    return (red ^ yellow ^ green) & ~(red & yellow & green);
  endfunction

endpackage

// File: rtl/ped_signal_if.sv
// Bundle between the light FSM / lamp drivers (master) and the crossing controller (slave).
interface ped_signal_if
  import ped_signal_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             enable;
  logic             red;
  logic             yellow;
  logic             green;
  logic             ped_button;
  logic             walk;
  logic             dont_walk;
  logic [CNT_W-1:0] countdown;
  logic             req_pending;
  logic             light_fault;

  modport master (
    output enable, red, yellow, green, ped_button,
    input  walk, dont_walk, countdown, req_pending, light_fault
  );

  modport slave (
    input  enable, red, yellow, green, ped_button,
    output walk, dont_walk, countdown, req_pending, light_fault
  );
endinterface

// File: rtl/ped_signal_ctrl_sync.sv
// Two-flop synchroniser for the raw push button followed by a one-clock rising-edge pulse,
// so a button held for any length of time yields a single request.
module button_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_async,
  output logic rise
);
  logic [1:0] sync_reg;
  logic       prev_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= 2'b00;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], btn_async};
      prev_reg <= sync_reg[1];
    end
  end

  assign rise = sync_reg[1] & ~prev_reg;
endmodule

// File: rtl/ped_signal_ctrl.sv
// Pedestrian WALK / DON'T-WALK controller slaved to the traffic-light FSM outputs.
// WALK is only granted on a red rising edge; loss of red or an illegal light pattern forces DON'T-WALK.
module ped_signal_ctrl
  import ped_signal_pkg::*;
#(
  parameter int WALK_TICKS  = WALK_TICKS_DEF,
  parameter int FLASH_TICKS = FLASH_TICKS_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  ped_signal_if.slave bus
);
  localparam logic [CNT_W-1:0] WALK_LOAD   = CNT_W'(WALK_TICKS - 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD  = CNT_W'(FLASH_TICKS - 1);
  localparam logic [CNT_W-1:0] FLASH_FIRST = CNT_W'(FLASH_TICKS);

  ped_state_e       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] countdown_reg;
  logic             walk_reg;
  logic             dont_walk_reg;
  logic             req_pending_reg;
  logic             light_fault_reg;
  logic             red_q_reg;
  logic             flash_phase_reg;

  logic req_edge;
  logic red_rise;
  logic lights_bad;

  button_sync_edge u_btn (
    .clk       (clk),
    .reset     (reset),
    .btn_async (bus.ped_button),
    .rise      (req_edge)
  );

  assign red_rise   = bus.red & ~red_q_reg;
  assign lights_bad = ~lights_one_hot(bus.red, bus.yellow, bus.green);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= DW_STEADY;
      cnt_reg         <= '0;
      countdown_reg   <= '0;
      walk_reg        <= 1'b0;
      dont_walk_reg   <= 1'b1;
      req_pending_reg <= 1'b0;
      light_fault_reg <= 1'b0;
      red_q_reg       <= 1'b0;
      flash_phase_reg <= 1'b0;
    end else begin
      red_q_reg <= bus.red;
      if (lights_bad) begin
        light_fault_reg <= 1'b1;
      end

      // The faulting cycle itself already forces the safe lamps, not just later ones.
      if (lights_bad || light_fault_reg) begin
        state_reg     <= DW_STEADY;
        walk_reg      <= 1'b0;
        dont_walk_reg <= 1'b1;
        countdown_reg <= '0;
        if (req_edge) begin
          req_pending_reg <= 1'b1;
        end
      end else begin
        case (state_reg)
          DW_STEADY: begin
            walk_reg      <= 1'b0;
            dont_walk_reg <= 1'b1;
            countdown_reg <= '0;
            if (red_rise && (req_pending_reg || req_edge)) begin
              state_reg       <= WALK;
              cnt_reg         <= WALK_LOAD;
              req_pending_reg <= 1'b0;
              walk_reg        <= 1'b1;
              dont_walk_reg   <= 1'b0;
            end else if (req_edge) begin
              req_pending_reg <= 1'b1;
            end
          end

          WALK: begin
            if (!bus.red) begin
              state_reg     <= DW_STEADY;
              walk_reg      <= 1'b0;
              dont_walk_reg <= 1'b1;
              countdown_reg <= '0;
            end else if (bus.enable) begin
              if (cnt_reg == '0) begin
                state_reg       <= FLASH;
                cnt_reg         <= FLASH_LOAD;
                flash_phase_reg <= 1'b1;
                walk_reg        <= 1'b0;
                dont_walk_reg   <= 1'b1;
                countdown_reg   <= FLASH_FIRST;
              end else begin
                cnt_reg <= cnt_reg - 1'b1;
              end
            end
          end

          FLASH: begin
            if (req_edge) begin
              req_pending_reg <= 1'b1;
            end
            if (!bus.red) begin
              state_reg     <= DW_STEADY;
              walk_reg      <= 1'b0;
              dont_walk_reg <= 1'b1;
              countdown_reg <= '0;
            end else if (bus.enable) begin
              flash_phase_reg <= ~flash_phase_reg;
              if (cnt_reg == '0) begin
                state_reg     <= DW_STEADY;
                dont_walk_reg <= 1'b1;
                countdown_reg <= '0;
              end else begin
                // Decremented count plus one is the current count.
                cnt_reg       <= cnt_reg - 1'b1;
                countdown_reg <= cnt_reg;
                dont_walk_reg <= ~flash_phase_reg;
              end
            end
          end

          default: begin
            state_reg     <= DW_STEADY;
            walk_reg      <= 1'b0;
            dont_walk_reg <= 1'b1;
            countdown_reg <= '0;
          end
        endcase
      end
    end
  end

  assign bus.walk        = walk_reg;
  assign bus.dont_walk   = dont_walk_reg;
  assign bus.countdown   = countdown_reg;
  assign bus.req_pending = req_pending_reg;
  assign bus.light_fault = light_fault_reg;
endmodule
